mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 6 +
 rtl/mem_io_responder_if.sv | 23 ++
 rtl/memio_fifo.sv | 49 ++++
 rtl/mem_io_responder.sv | 87 ++++++++
 tb/tb_mem_io_responder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: IO map constants shared with the memory controller
package mem_io_responder_pkg;
    localparam logic [1:0]  IO_TAG  = 2'b11;
    localparam logic [31:0] IO_DATA = 32'h0003_0000;
    localparam logic [31:0] IO_CTRL = 32'h0003_0004;
endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: controller bus plus console streams and halt flag
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        halt;
    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, halt
    );
    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, halt
    );
endinterface

// File: rtl/memio_fifo.sv
// memio_fifo: byte FIFO; a push while full is accepted only alongside a pop
module memio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CNT_FULL;
    assign count = cnt_q;
    assign head  = mem[rp_q];
    // accepted push/pop and wrapped pointer/count updates
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wp_d    = wp_q + {{(PW-1){1'b0}}, do_push};
        rp_d    = rp_q + {{(PW-1){1'b0}}, do_pop};
        cnt_d   = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
    // pointer and count state
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    // storage is not reset; the count marks valid entries
    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q] <= din;
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped console IO; macro MEMIO_RX_EN enables the RX path
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_io_responder_if.slave bus
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam logic [TPW:0] TX_HI = (TPW+1)'(TX_DEPTH - 1);
    logic [7:0]  ram [2**ADDR_W];
    logic [7:0]  mem_din_q, mem_din_d;
    logic        io_buffer_full_q, io_buffer_full_d;
    logic        halt_q, halt_d;
    logic        is_io, io_data, io_ctrl;
    logic        tx_push, tx_pop, tx_push_ok, tx_full, tx_empty;
    logic [TPW:0] tx_count, tx_count_nx;
    logic [7:0]  tx_head;
    logic        rx_pop, rx_ne;
    logic [7:0]  rx_byte;
    logic        unused_bits;
    memio_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.mem_dout),
        .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
    );
`ifdef MEMIO_RX_EN
    localparam int RPW = $clog2(RX_DEPTH);
    logic         rx_full, rx_empty;
    logic [RPW:0] rx_count_unused;
    logic [7:0]   rx_head;
    memio_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(bus.rx_valid && !rx_full), .pop(rx_pop), .din(bus.rx_data),
        .full(rx_full), .empty(rx_empty), .count(rx_count_unused), .head(rx_head)
    );
    assign bus.rx_ready = !rx_full;
    assign rx_ne        = !rx_empty;
    assign rx_byte      = rx_empty ? 8'h00 : rx_head;
    assign unused_bits  = ^bus.mem_a;
`else
    assign bus.rx_ready = 1'b0;
    assign rx_ne        = 1'b0;
    assign rx_byte      = 8'h00;
    assign unused_bits  = ^{bus.mem_a, bus.rx_valid, bus.rx_data, rx_pop};
`endif
    assign bus.mem_din        = mem_din_q;
    assign bus.io_buffer_full = io_buffer_full_q;
    assign bus.halt           = halt_q;
    assign bus.tx_valid       = !tx_empty;
    assign bus.tx_data        = tx_head;
    // address decode, FIFO strobes, read mux and next-state of status flags
    always_comb begin
        is_io      = bus.mem_a[17:16] == IO_TAG;
        io_data    = bus.mem_a[17:0] == IO_DATA[17:0];
        io_ctrl    = bus.mem_a[17:0] == IO_CTRL[17:0];
        tx_push    = io_data && bus.mem_wr;
        rx_pop     = io_data && !bus.mem_wr;
        tx_pop     = !tx_empty && bus.tx_ready;
        tx_push_ok = tx_push && (!tx_full || tx_pop);
        tx_count_nx = tx_count + {{TPW{1'b0}}, tx_push_ok} - {{TPW{1'b0}}, tx_pop};
        io_buffer_full_d = tx_count_nx >= TX_HI;
        halt_d     = halt_q || (io_ctrl && bus.mem_wr);
        mem_din_d  = bus.mem_wr ? mem_din_q :
                     !is_io     ? ram[bus.mem_a[ADDR_W-1:0]] :
                     io_data    ? rx_byte :
                     io_ctrl    ? {6'b0, rx_ne, tx_empty} : 8'h00;
    end
    // registered read data and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din_q        <= 8'h00;
            io_buffer_full_q <= 1'b0;
            halt_q           <= 1'b0;
        end else begin
            mem_din_q        <= mem_din_d;
            io_buffer_full_q <= io_buffer_full_d;
            halt_q           <= halt_d;
        end
    end
    // RAM writes; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.mem_wr && !is_io) ram[bus.mem_a[ADDR_W-1:0]] <= bus.mem_dout;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed vector table plus hand-written TX/RX/halt sequences
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    mem_io_responder_if bus();
    mem_io_responder dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic [7:0]  e_din;
        logic        e_txv;
        logic [7:0]  e_txd;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.mem_a = a;
        bus.mem_wr = wr;
        bus.mem_dout = d;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        vecs[0]  = '{"ram_wr",      32'h00100, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{"ram_rd",      32'h00100, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{"ram_wr_keep", 32'h00000, 1'b1, 8'h5A, 8'hA5, 1'b0, 8'h00};
        vecs[3]  = '{"idle_rd",     32'h00000, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h00};
        vecs[4]  = '{"tx_push41",   32'h30000, 1'b1, 8'h41, 8'h5A, 1'b1, 8'h41};
        vecs[5]  = '{"tx_push42",   32'h30000, 1'b1, 8'h42, 8'h5A, 1'b1, 8'h41};
        vecs[6]  = '{"tx_push43",   32'h30000, 1'b1, 8'h43, 8'h5A, 1'b1, 8'h41};
        vecs[7]  = '{"ctrl_rd",     32'h30004, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41};
        vecs[8]  = '{"ram_rd2",     32'h00100, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h41};
        vecs[9]  = '{"other_io_rd", 32'h30008, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41};
        vecs[10] = '{"other_io_wr", 32'h30008, 1'b1, 8'h77, 8'h00, 1'b1, 8'h41};
        drive(32'h0, 1'b0, 8'h00);
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_din", bus.mem_din, 8'h00);
        chk("rst_full", bus.io_buffer_full, 1'b0);
        chk("rst_halt", bus.halt, 1'b0);
        chk("rst_txv", bus.tx_valid, 1'b0);
`ifdef MEMIO_RX_EN
        chk("rst_rx_ready", bus.rx_ready, 1'b1);
`else
        chk("rst_rx_ready", bus.rx_ready, 1'b0);
`endif
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].a, vecs[i].wr, vecs[i].d);
            cyc();
            chk({vecs[i].nm, "_din"}, bus.mem_din, vecs[i].e_din);
            chk({vecs[i].nm, "_txv"}, bus.tx_valid, vecs[i].e_txv);
            chk({vecs[i].nm, "_full"}, bus.io_buffer_full, 1'b0);
            if (vecs[i].e_txv) chk({vecs[i].nm, "_txd"}, bus.tx_data, vecs[i].e_txd);
        end
        drive(32'h0, 1'b0, 8'h00);
        bus.tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_txv", bus.tx_valid, 1'b1);
            chk("drain_txd", bus.tx_data, 8'h41 + 8'(i));
            cyc();
        end
        chk("drain_empty", bus.tx_valid, 1'b0);
        bus.tx_ready = 1'b0;
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("ctrl_tx_empty", bus.mem_din, 8'h01);
        for (int i = 0; i < 9; i++) begin
            drive(32'h30000, 1'b1, 8'h10 + 8'(i));
            cyc();
            chk("fill_full", bus.io_buffer_full, i >= 6 ? 1'b1 : 1'b0);
            if (i < 8) exp_q.push_back(8'h10 + 8'(i));
        end
        drive(32'h30000, 1'b1, 8'h19);
        bus.tx_ready = 1'b1;
        #1;
        chk("full_pop_head", bus.tx_data, 8'h10);
        cyc();
        void'(exp_q.pop_front());
        exp_q.push_back(8'h19);
        chk("full_pushpop_full", bus.io_buffer_full, 1'b1);
        drive(32'h0, 1'b0, 8'h00);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("wrap_txv", bus.tx_valid, 1'b1);
            chk("wrap_txd", bus.tx_data, exp_q[i]);
            cyc();
        end
        chk("wrap_empty", bus.tx_valid, 1'b0);
        chk("wrap_full_clr", bus.io_buffer_full, 1'b0);
        bus.tx_ready = 1'b0;
`ifdef MEMIO_RX_EN
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h31;
        cyc();
        bus.rx_data = 8'h32;
        cyc();
        bus.rx_valid = 1'b0;
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("ctrl_rx_ne", bus.mem_din, 8'h03);
        drive(32'h30000, 1'b0, 8'h00);
        cyc();
        chk("rx_rd1", bus.mem_din, 8'h31);
        drive(32'h00100, 1'b0, 8'h00);
        cyc();
        cyc();
        drive(32'h30000, 1'b0, 8'h00);
        cyc();
        chk("rx_rd2", bus.mem_din, 8'h32);
        cyc();
        chk("rx_rd_empty", bus.mem_din, 8'h00);
`else
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h31;
        drive(32'h00100, 1'b0, 8'h00);
        cyc();
        bus.rx_valid = 1'b0;
        drive(32'h30000, 1'b0, 8'h00);
        cyc();
        chk("norx_data_rd", bus.mem_din, 8'h00);
        chk("norx_ready", bus.rx_ready, 1'b0);
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("norx_ctrl", bus.mem_din, 8'h01);
`endif
        drive(32'h30004, 1'b1, 8'h00);
        cyc();
        chk("halt_set", bus.halt, 1'b1);
        drive(32'h0, 1'b0, 8'h00);
        cyc();
        cyc();
        chk("halt_held", bus.halt, 1'b1);
        drive(32'h30000, 1'b1, 8'h55);
        cyc();
        chk("pre_rst_txv", bus.tx_valid, 1'b1);
        drive(32'h00100, 1'b0, 8'h00);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_halt", bus.halt, 1'b0);
        chk("rst2_txv", bus.tx_valid, 1'b0);
        chk("rst2_din", bus.mem_din, 8'h00);
        cyc();
        chk("ram_survives_rst", bus.mem_din, 8'hA5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
